// File: rtl/sseg_bcd_mux.sv
// Multiplexed seven-segment driver with a sequential double-dabble
// binary-to-BCD converter, signed/unsigned display and overflow marking.
module sseg_bcd_mux #(
  parameter int DIGITS      = 4,
  parameter int IN_W        = 11,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in,
  input  logic              sel,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              ovf
);

  function automatic int ndig(input int w);
    longint m;
    int n;
    m = (longint'(1) << w) - 1;
    n = 1;
    for (int i = 0; i < 12; i++) begin
      if (m >= 10) begin
        m = m / 10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int NB = ndig(IN_W);
  localparam int XN = (NB > DIGITS) ? NB : DIGITS;
  localparam int DW = NB * 4 + IN_W;
  localparam int CW = $clog2(IN_W + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              st;
  logic [CW-1:0]       cnt;
  logic [DW-1:0]       dd;
  logic                neg;
  logic                mode;
  logic [NB*4-1:0]     bcd;
  logic [NB*4-1:0]     adj;
  logic [XN*4-1:0]     bcdx;
  logic [IN_W-1:0]     mag_n;
  logic                lovf;

  logic [DIGITS-1:0][3:0] ddig;
  logic                dneg;
  logic                dmode;
  logic                dovf;

  logic [RW-1:0]       rcnt;
  logic [IW-1:0]       idx;

  assign bcd   = dd[DW-1:IN_W];
  assign bcdx  = (XN*4)'(bcd);
  assign mag_n = (sel && in[IN_W-1]) ? IN_W'(-in) : in;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NB; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Nibbles beyond the digits available in the current mode flag overflow
  always_comb begin
    int av;
    av   = mode ? DIGITS - 1 : DIGITS;
    lovf = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i >= av && bcd[4*i +: 4] != 4'd0)
        lovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      cnt   <= '0;
      dd    <= '0;
      neg   <= 1'b0;
      mode  <= 1'b0;
      ddig  <= '0;
      dneg  <= 1'b0;
      dmode <= 1'b0;
      dovf  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          dd   <= {{(NB*4){1'b0}}, mag_n};
          neg  <= sel & in[IN_W-1];
          mode <= sel;
          cnt  <= '0;
          st   <= SHIFT;
        end
        SHIFT: begin
          dd  <= {adj, dd[IN_W-1:0]} << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(IN_W - 1))
            st <= LATCH;
        end
        LATCH: begin
          ddig  <= bcdx[DIGITS*4-1:0];
          dneg  <= neg;
          dmode <= mode;
          dovf  <= lovf;
          st    <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RMAX) begin
      rcnt <= '0;
      idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  always_comb begin
    int   av;
    logic hz;
    av = dmode ? DIGITS - 1 : DIGITS;
    hz = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx) && j < av && ddig[j] != 4'd0)
        hz = 1'b0;
    end
    if (dovf)
      seg = MINUS;
    else if (dmode && int'(idx) == DIGITS - 1)
      seg = dneg ? MINUS : BLANK;
    else if (idx != '0 && hz)
      seg = BLANK;
    else
      seg = dec(ddig[idx]);
  end

  assign an  = ~(DIGITS'(1) << idx);
  assign dp  = 1'b1;
  assign ovf = dovf;

endmodule

// File: tb/tb_sseg_bcd_mux.sv
// Bench for sseg_bcd_mux: randomized and directed values checked
// against a decimal-arithmetic display model.
module tb_sseg_bcd_mux;

  localparam int DIGITS = 4;
  localparam int IN_W   = 11;
  localparam int RDIV   = 4;
  localparam int WORST  = 2 * IN_W + 3;
  localparam int SCAN   = DIGITS * RDIV;

  logic              clk;
  logic              rst_n;
  logic [IN_W-1:0]   in_v;
  logic              sel;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              dp;
  logic              ovf;

  int tests;
  int fails;

  logic [6:0] exp_seg [DIGITS];
  logic       exp_ovf;
  logic [6:0] tbl [10];

  sseg_bcd_mux #(
    .DIGITS(DIGITS),
    .IN_W(IN_W),
    .REFRESH_DIV(RDIV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in_v),
    .sel(sel),
    .an(an),
    .seg(seg),
    .dp(dp),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pow10(input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  task automatic model(input logic [IN_W-1:0] x, input logic s);
    int v;
    int m;
    int av;
    v  = (s && x[IN_W-1]) ? int'(x) - (1 << IN_W) : int'(x);
    m  = (v < 0) ? -v : v;
    av = s ? DIGITS - 1 : DIGITS;
    exp_ovf = (m >= pow10(av));
    for (int d = 0; d < DIGITS; d++) begin
      if (exp_ovf)
        exp_seg[d] = 7'b0111111;
      else if (s && d == DIGITS - 1)
        exp_seg[d] = (v < 0) ? 7'b0111111 : 7'b1111111;
      else if (d > 0 && m < pow10(d))
        exp_seg[d] = 7'b1111111;
      else
        exp_seg[d] = tbl[(m / pow10(d)) % 10];
    end
  endtask

  task automatic watch(output int pos, output logic [6:0] sg,
                       output logic ov, output logic dq);
    int z;
    @(negedge clk);
    z   = 0;
    pos = -1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) begin
        z++;
        pos = i;
      end
    end
    if (z != 1) pos = -1;
    sg = seg;
    ov = ovf;
    dq = dp;
  endtask

  task automatic set_in(input logic [IN_W-1:0] x, input logic s);
    @(negedge clk);
    in_v = x;
    sel  = s;
    repeat (WORST) @(posedge clk);
    model(x, s);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    in_v  = '0;
    sel   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset: got an=%b seg=%b dp=%b ovf=%b want 1110 1000000 1 0",
               an, seg, dp, ovf);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    logic [IN_W-1:0] vals [2];
    int pos;
    logic [6:0] sg;
    logic ov, dq;
    vals[0] = 11'd1234;
    vals[1] = 11'd2047;
    for (int k = 0; k < 2; k++) begin
      set_in(vals[k], 1'b0);
      for (int c = 0; c < SCAN; c++) begin
        watch(pos, sg, ov, dq);
        tests++;
        if (pos < 0) begin
          fails++;
          $display("FAIL unsigned %0d an: got %b want one-hot-low", vals[k], an);
        end else if (sg !== exp_seg[pos] || ov !== exp_ovf || dq !== 1'b1) begin
          fails++;
          $display("FAIL unsigned %0d digit%0d: got seg=%b ovf=%b dp=%b want seg=%b ovf=%b dp=1",
                   vals[k], pos, sg, ov, dq, exp_seg[pos], exp_ovf);
        end
      end
    end
  endtask

  task automatic test_blanking;
    logic [IN_W-1:0] vals [3];
    int pos;
    logic [6:0] sg;
    logic ov, dq;
    vals[0] = 11'd7;
    vals[1] = 11'd0;
    vals[2] = 11'd100;
    for (int k = 0; k < 3; k++) begin
      set_in(vals[k], 1'b0);
      for (int c = 0; c < SCAN; c++) begin
        watch(pos, sg, ov, dq);
        tests++;
        if (pos < 0) begin
          fails++;
          $display("FAIL blank %0d an: got %b want one-hot-low", vals[k], an);
        end else if (sg !== exp_seg[pos] || ov !== exp_ovf) begin
          fails++;
          $display("FAIL blank %0d digit%0d: got seg=%b ovf=%b want seg=%b ovf=%b",
                   vals[k], pos, sg, ov, exp_seg[pos], exp_ovf);
        end
      end
    end
  endtask

  task automatic test_signed;
    logic [IN_W-1:0] vals [5];
    int pos;
    logic [6:0] sg;
    logic ov, dq;
    vals[0] = 11'h7FF;
    vals[1] = 11'(-999);
    vals[2] = 11'h400;
    vals[3] = 11'd1023;
    vals[4] = 11'd0;
    for (int k = 0; k < 5; k++) begin
      set_in(vals[k], 1'b1);
      for (int c = 0; c < SCAN; c++) begin
        watch(pos, sg, ov, dq);
        tests++;
        if (pos < 0) begin
          fails++;
          $display("FAIL signed %h an: got %b want one-hot-low", vals[k], an);
        end else if (sg !== exp_seg[pos] || ov !== exp_ovf) begin
          fails++;
          $display("FAIL signed %h digit%0d: got seg=%b ovf=%b want seg=%b ovf=%b",
                   vals[k], pos, sg, ov, exp_seg[pos], exp_ovf);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [IN_W-1:0] x;
    logic s;
    int pos;
    logic [6:0] sg;
    logic ov, dq;
    for (int k = 0; k < 20; k++) begin
      x = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      s = 1'($urandom_range(0, 1));
      set_in(x, s);
      for (int c = 0; c < SCAN; c++) begin
        watch(pos, sg, ov, dq);
        tests++;
        if (pos < 0) begin
          fails++;
          $display("FAIL random %h/%0d an: got %b want one-hot-low", x, s, an);
        end else if (sg !== exp_seg[pos] || ov !== exp_ovf) begin
          fails++;
          $display("FAIL random %h/%0d digit%0d: got seg=%b ovf=%b want seg=%b ovf=%b",
                   x, s, pos, sg, ov, exp_seg[pos], exp_ovf);
        end
      end
    end
  endtask

  // After release, edge 1 samples, edge 13 latches; the next sample is edge 14
  task automatic test_midconv;
    int pos;
    logic [6:0] sg;
    logic ov, dq;
    @(negedge clk);
    rst_n = 1'b0;
    in_v  = 11'd5;
    sel   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk);
      watch(pos, sg, ov, dq);
      if (k == 3) in_v = 11'd9;
      if (k >= 13) begin
        model((k <= 25) ? 11'd5 : 11'd9, 1'b0);
        tests++;
        if (pos < 0) begin
          fails++;
          $display("FAIL midconv k=%0d an: got %b want one-hot-low", k, an);
        end else if (sg !== exp_seg[pos] || ov !== exp_ovf) begin
          fails++;
          $display("FAIL midconv k=%0d digit%0d: got seg=%b want seg=%b",
                   k, pos, sg, exp_seg[pos]);
        end
      end
    end
  endtask

  task automatic test_reset_midconv;
    int pos;
    logic [6:0] sg;
    logic ov, dq;
    in_v = 11'd88;
    sel  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got an=%b seg=%b dp=%b ovf=%b want 1110 1000000 1 0",
               an, seg, dp, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (IN_W + 2) @(posedge clk);
    model(11'd88, 1'b0);
    for (int c = 0; c < SCAN; c++) begin
      watch(pos, sg, ov, dq);
      tests++;
      if (pos < 0) begin
        fails++;
        $display("FAIL reset_mid an: got %b want one-hot-low", an);
      end else if (sg !== exp_seg[pos] || ov !== exp_ovf) begin
        fails++;
        $display("FAIL reset_mid digit%0d: got seg=%b want seg=%b",
                 pos, sg, exp_seg[pos]);
      end
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    tbl[0] = 7'b1000000;
    tbl[1] = 7'b1111001;
    tbl[2] = 7'b0100100;
    tbl[3] = 7'b0110000;
    tbl[4] = 7'b0011001;
    tbl[5] = 7'b0010010;
    tbl[6] = 7'b0000010;
    tbl[7] = 7'b1111000;
    tbl[8] = 7'b0000000;
    tbl[9] = 7'b0010000;
    test_reset();
    test_unsigned();
    test_blanking();
    test_signed();
    test_random();
    test_midconv();
    test_reset_midconv();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
